// File: rtl/xbar_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : xbar_req_arb
// Description : Request-side arbiter for the cross bar. Channels 0-2 share the
//               HTU request port and the write-buffer request port. A
//               one-entry issue slot holds the granted request. Every write
//               gets a write-buffer ID from a free pool. IDs return to the
//               pool on release pulses from the write buffer.
//               Define XBAR_ARB_FIXED_PRIO_EN to replace round-robin with
//               fixed priority ch0 > ch1 > ch2.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_req_arb #(
    parameter int WBUF_DEPTH = 16,
    parameter int NUM_CH     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  ch0_valid_i,
    output logic                  ch0_ready_o,
    input  logic [2:0]            ch0_op_i,
    input  logic [27:0]           ch0_addr_i,
    input  logic [127:0]          ch0_data_i,

    input  logic                  ch1_valid_i,
    output logic                  ch1_ready_o,
    input  logic [2:0]            ch1_op_i,
    input  logic [27:0]           ch1_addr_i,
    input  logic [127:0]          ch1_data_i,

    input  logic                  ch2_valid_i,
    output logic                  ch2_ready_o,
    input  logic [2:0]            ch2_op_i,
    input  logic [27:0]           ch2_addr_i,
    input  logic [127:0]          ch2_data_i,

    output logic                  xbar_htu_valid_o,
    input  logic                  xbar_htu_ready_i,
    output logic [1:0]            xbar_htu_ch_id_o,
    output logic [1:0]            xbar_htu_opcode_o,
    output logic [31:0]           xbar_htu_addr_o,
    output logic [2:0]            xbar_htu_set_o,
    output logic [7:0]            xbar_htu_wbuffer_id_o,

    output logic                  xbar_wbuf_req_valid_o,
    input  logic                  xbar_wbuf_req_ready_i,
    output logic [1:0]            xbar_wbuf_req_ch_id_o,
    output logic [127:0]          xbar_wbuf_req_data_o,
    output logic [7:0]            xbar_wbuf_req_wbuffer_id_o,

    input  logic [WBUF_DEPTH-1:0] xbar_wbuf_rtn_free_id_i
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Slot state
    logic                  htu_pend;
    logic                  wbuf_pend;
    logic [WBUF_DEPTH-1:0] free_map;
`ifndef XBAR_ARB_FIXED_PRIO_EN
    logic [1:0]            rr_ptr;
`endif

    // Arbitration
    logic [NUM_CH-1:0]     req_valid;
    logic [2:0]            req_op [NUM_CH];
    logic [NUM_CH-1:0]     eligible;
    logic [3:0]            eligible_pad;
    logic                  pool_nonempty;
    logic                  accept_ok;
    logic                  found;
    logic [1:0]            cand;
    logic [1:0]            grant_ch;
    logic                  grant;

    // Selected payload
    logic [2:0]            sel_op;
    logic [27:0]           sel_addr;
    logic [127:0]          sel_data;
    logic                  is_write;
    logic                  take_write;

    // ID allocation
    logic                  alloc_found;
    logic [7:0]            alloc_id;
    logic [WBUF_DEPTH-1:0] alloc_onehot;

    // op[2] carries no meaning for this block
    logic                  unused_op_msb;
    assign unused_op_msb = ch0_op_i[2] ^ ch1_op_i[2] ^ ch2_op_i[2];

    assign req_valid = {ch2_valid_i, ch1_valid_i, ch0_valid_i};
    assign req_op[0] = ch0_op_i;
    assign req_op[1] = ch1_op_i;
    assign req_op[2] = ch2_op_i;

    assign pool_nonempty = |free_map;

    // A write is only eligible while at least one ID is free
    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_elig
            assign eligible[n] = req_valid[n] &
                                 ((req_op[n][1:0] != OP_WRITE) | pool_nonempty);
        end
    endgenerate

    assign eligible_pad = {{(4 - NUM_CH){1'b0}}, eligible};

    // The slot can take a new request when every pending side completes now
    assign accept_ok = (~htu_pend  | xbar_htu_ready_i) &
                       (~wbuf_pend | xbar_wbuf_req_ready_i);

    // Pick the first eligible channel starting at the search origin
    always_comb begin
        found    = 1'b0;
        grant_ch = 2'd0;
        cand     = 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef XBAR_ARB_FIXED_PRIO_EN
            cand = 2'(k);
`else
            cand = ((int'(rr_ptr) + k) >= NUM_CH) ? 2'(int'(rr_ptr) + k - NUM_CH)
                                                  : 2'(int'(rr_ptr) + k);
`endif
            if (!found && eligible_pad[cand]) begin
                found    = 1'b1;
                grant_ch = cand;
            end
        end
    end

    assign grant = rst_i & accept_ok & found;

    assign ch0_ready_o = grant & (grant_ch == 2'd0);
    assign ch1_ready_o = grant & (grant_ch == 2'd1);
    assign ch2_ready_o = grant & (grant_ch == 2'd2);

    // Route the granted channel's payload to the slot
    always_comb begin
        sel_op   = ch0_op_i;
        sel_addr = ch0_addr_i;
        sel_data = ch0_data_i;
        case (grant_ch)
            2'd1: begin
                sel_op   = ch1_op_i;
                sel_addr = ch1_addr_i;
                sel_data = ch1_data_i;
            end
            2'd2: begin
                sel_op   = ch2_op_i;
                sel_addr = ch2_addr_i;
                sel_data = ch2_data_i;
            end
            default: ;
        endcase
    end

    assign is_write   = (sel_op[1:0] == OP_WRITE);
    assign take_write = grant & is_write;

    // Lowest free ID; its bit is marked for clearing only on a write grant
    always_comb begin
        alloc_found  = 1'b0;
        alloc_id     = 8'd0;
        alloc_onehot = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (!alloc_found && free_map[i]) begin
                alloc_found     = 1'b1;
                alloc_id        = 8'(i);
                alloc_onehot[i] = take_write;
            end
        end
    end

    // Issue slot: each side retires on its own handshake, a grant refills both
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            htu_pend                   <= 1'b0;
            wbuf_pend                  <= 1'b0;
            xbar_htu_ch_id_o           <= 2'd0;
            xbar_htu_opcode_o          <= 2'd0;
            xbar_htu_addr_o            <= 32'd0;
            xbar_htu_set_o             <= 3'd0;
            xbar_htu_wbuffer_id_o      <= 8'd0;
            xbar_wbuf_req_ch_id_o      <= 2'd0;
            xbar_wbuf_req_data_o       <= 128'd0;
            xbar_wbuf_req_wbuffer_id_o <= 8'd0;
        end else begin
            if (xbar_htu_ready_i) begin
                htu_pend <= 1'b0;
            end
            if (xbar_wbuf_req_ready_i) begin
                wbuf_pend <= 1'b0;
            end
            if (grant) begin
                htu_pend              <= 1'b1;
                wbuf_pend             <= is_write;
                xbar_htu_ch_id_o      <= grant_ch;
                xbar_htu_opcode_o     <= (sel_op[1:0] == OP_RSVD) ? 2'b00 : sel_op[1:0];
                xbar_htu_addr_o       <= {sel_addr, 4'b0000};
                xbar_htu_set_o        <= sel_addr[2:0];
                xbar_htu_wbuffer_id_o <= is_write ? alloc_id : 8'd0;
                // Write-buffer fields only change when a write enters the slot
                if (is_write) begin
                    xbar_wbuf_req_ch_id_o      <= grant_ch;
                    xbar_wbuf_req_data_o       <= sel_data;
                    xbar_wbuf_req_wbuffer_id_o <= alloc_id;
                end
            end
        end
    end

    assign xbar_htu_valid_o      = htu_pend;
    assign xbar_wbuf_req_valid_o = wbuf_pend;

    // Free-ID pool: returns are merged, then the allocated bit is taken out
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            free_map <= '1;
        end else begin
            free_map <= (free_map | xbar_wbuf_rtn_free_id_i) & ~alloc_onehot;
        end
    end

`ifndef XBAR_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past the channel that was granted
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_ptr <= 2'd0;
        end else if (grant) begin
            rr_ptr <= (grant_ch == 2'd2) ? 2'd0 : grant_ch + 2'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbar_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_req_arb
// Description : Self-checking bench for xbar_req_arb with a request-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_req_arb;

    localparam int WBUF_DEPTH = 16;

    typedef struct packed {
        logic [2:0]   op;
        logic [27:0]  addr;
        logic [127:0] data;
    } req_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  valid [3];
    logic [2:0]            op    [3];
    logic [27:0]           addr  [3];
    logic [127:0]          data  [3];
    logic                  ready0, ready1, ready2;
    logic                  htu_ready, wbuf_ready;
    logic [WBUF_DEPTH-1:0] free_id;

    logic                  htu_valid, wb_valid;
    logic [1:0]            htu_ch, htu_opc, wb_ch;
    logic [31:0]           htu_addr;
    logic [2:0]            htu_set;
    logic [7:0]            htu_id, wb_id;
    logic [127:0]          wb_data;

    always #5 clk = ~clk;

    xbar_req_arb #(.WBUF_DEPTH(WBUF_DEPTH), .NUM_CH(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .ch0_valid_i(valid[0]), .ch0_ready_o(ready0), .ch0_op_i(op[0]),
        .ch0_addr_i(addr[0]), .ch0_data_i(data[0]),
        .ch1_valid_i(valid[1]), .ch1_ready_o(ready1), .ch1_op_i(op[1]),
        .ch1_addr_i(addr[1]), .ch1_data_i(data[1]),
        .ch2_valid_i(valid[2]), .ch2_ready_o(ready2), .ch2_op_i(op[2]),
        .ch2_addr_i(addr[2]), .ch2_data_i(data[2]),
        .xbar_htu_valid_o(htu_valid), .xbar_htu_ready_i(htu_ready),
        .xbar_htu_ch_id_o(htu_ch), .xbar_htu_opcode_o(htu_opc),
        .xbar_htu_addr_o(htu_addr), .xbar_htu_set_o(htu_set),
        .xbar_htu_wbuffer_id_o(htu_id),
        .xbar_wbuf_req_valid_o(wb_valid), .xbar_wbuf_req_ready_i(wbuf_ready),
        .xbar_wbuf_req_ch_id_o(wb_ch), .xbar_wbuf_req_data_o(wb_data),
        .xbar_wbuf_req_wbuffer_id_o(wb_id),
        .xbar_wbuf_rtn_free_id_i(free_id)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Source request queues: head is presented until granted
    req_t chq [3][$];

    // Reference model: what the slot must hold, as plain request-level state
    logic                  m_htu_pend, m_wbuf_pend;
    logic [1:0]            m_ch, m_opc, m_wch;
    logic [31:0]           m_addr;
    logic [2:0]            m_set;
    logic [7:0]            m_hid, m_wid;
    logic [127:0]          m_wdata;
    logic [WBUF_DEPTH-1:0] m_free;
    int                    m_rr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (m_free[i]) return i;
        end
        return -1;
    endfunction

    // Channel that must be granted this cycle, or -1
    function automatic int model_pick();
        int start;
        if (rst !== 1'b1) return -1;
        if (m_htu_pend && !htu_ready) return -1;
        if (m_wbuf_pend && !wbuf_ready) return -1;
`ifdef XBAR_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_rr;
`endif
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (start + k) % 3;
            if (valid[c] && (op[c][1:0] != 2'b01 || m_free != '0)) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        int g;
        int id;
        bit w;
        if (!rst) begin
            m_htu_pend = 0; m_wbuf_pend = 0;
            m_ch = 0; m_opc = 0; m_addr = 0; m_set = 0; m_hid = 0;
            m_wch = 0; m_wdata = 0; m_wid = 0;
            m_free = '1; m_rr = 0;
            return;
        end
        g = model_pick();
        if (htu_ready)  m_htu_pend  = 1'b0;
        if (wbuf_ready) m_wbuf_pend = 1'b0;
        if (g >= 0) begin
            w  = (op[g][1:0] == 2'b01);
            id = 0;
            if (w) begin
                id = lowest_free();
                m_free[id] = 1'b0;
            end
            m_htu_pend  = 1'b1;
            m_wbuf_pend = w;
            m_ch   = 2'(g);
            m_opc  = (op[g][1:0] == 2'b11) ? 2'b00 : op[g][1:0];
            m_addr = {addr[g], 4'h0};
            m_set  = addr[g][2:0];
            m_hid  = w ? 8'(id) : 8'd0;
            if (w) begin
                m_wch   = 2'(g);
                m_wdata = data[g];
                m_wid   = 8'(id);
            end
            void'(chq[g].pop_front());
            m_rr = (g + 1) % 3;
        end
        m_free = m_free | free_id;
    endtask

    task automatic drive_sources();
        for (int n = 0; n < 3; n++) begin
            if (chq[n].size() > 0) begin
                valid[n] = 1'b1;
                op[n]    = chq[n][0].op;
                addr[n]  = chq[n][0].addr;
                data[n]  = chq[n][0].data;
            end else begin
                valid[n] = 1'b0;
            end
        end
    endtask

    task automatic push(input int ch, input logic [2:0] o, input logic [27:0] a, input logic [127:0] d);
        req_t r;
        r.op = o; r.addr = a; r.data = d;
        chq[ch].push_back(r);
        drive_sources();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        drive_sources();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b1;
    endtask

    // Every cycle: all DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int g;
            g = model_pick();
            check("ch0_ready", ready0, g == 0);
            check("ch1_ready", ready1, g == 1);
            check("ch2_ready", ready2, g == 2);
            check("htu_valid", htu_valid, m_htu_pend);
            check("htu_ch", htu_ch, m_ch);
            check("htu_opcode", htu_opc, m_opc);
            check("htu_addr", htu_addr, m_addr);
            check("htu_set", htu_set, m_set);
            check("htu_id", htu_id, m_hid);
            check("wb_valid", wb_valid, m_wbuf_pend);
            check("wb_ch", wb_ch, m_wch);
            check("wb_data", wb_data, m_wdata);
            check("wb_id", wb_id, m_wid);
        end
    end

    initial begin
        int got;
        int rr_exp [6];
        rst = 1'b0; htu_ready = 1'b0; wbuf_ready = 1'b0; free_id = '0;
        for (int n = 0; n < 3; n++) begin
            valid[n] = 1'b0; op[n] = '0; addr[n] = '0; data[n] = '0;
        end

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_htu_valid", htu_valid, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_htu_addr", htu_addr, 32'h0);
        check("rst_wb_data", wb_data, 128'h0);

        // Single read on ch0
        step();
        htu_ready = 1'b1; wbuf_ready = 1'b1;
        push(0, 3'b000, 28'h1234567, 128'h0);
        @(negedge clk);
        check("t1_ready0", ready0, 1'b1);
        step();
        @(negedge clk);
        check("t1_htu_valid", htu_valid, 1'b1);
        check("t1_addr", htu_addr, 32'h12345670);
        check("t1_set", htu_set, 3'b111);
        check("t1_ch", htu_ch, 2'd0);
        check("t1_opcode", htu_opc, 2'b00);
        check("t1_wb_valid", wb_valid, 1'b0);
        step();

        // Three channels streaming reads/flush/reserved ops
        do_reset();
`ifdef XBAR_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 1, 1, 2, 2};
`else
        rr_exp = '{0, 1, 2, 0, 1, 2};
`endif
        for (int i = 0; i < 2; i++) begin
            push(0, 3'b100, 28'h0000010 + 28'(i), 128'h0);
            push(1, 3'b010, 28'h0000020 + 28'(i), 128'h0);
            push(2, 3'b011, 28'h0000030 + 28'(i), 128'h0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got = ready0 ? 0 : ready1 ? 1 : ready2 ? 2 : 3;
            check("rr_order", got, rr_exp[i]);
            step();
        end
        step();

        // Write with stalled write buffer blocks the slot
        do_reset();
        wbuf_ready = 1'b0;
        push(1, 3'b001, 28'hABCDEF1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
        @(negedge clk);
        check("t3_ready1", ready1, 1'b1);
        step();
        push(0, 3'b000, 28'h0000100, 128'h0);
        @(negedge clk);
        check("t3_htu_valid", htu_valid, 1'b1);
        check("t3_wb_valid", wb_valid, 1'b1);
        check("t3_htu_id", htu_id, 8'd0);
        check("t3_wb_id", wb_id, 8'd0);
        check("t3_ready0_a", ready0, 1'b0);
        step();
        @(negedge clk);
        check("t3_htu_done", htu_valid, 1'b0);
        check("t3_ready0_b", ready0, 1'b0);
        step();
        @(negedge clk);
        check("t3_ready0_c", ready0, 1'b0);
        step();
        wbuf_ready = 1'b1;
        @(negedge clk);
        check("t3_ready0_d", ready0, 1'b1);
        step();
        step();

        // Pool exhaustion, release and reallocation
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(0, 3'b001, 28'h0001000 + 28'(i), 128'(i) + 128'h100);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            @(negedge clk);
            check("t4_id_seq", wb_id, 8'(i));
        end
        check("t4_stall", ready0, 1'b0);
        step();
        push(2, 3'b000, 28'h0002000, 128'h0);
        @(negedge clk);
        check("t4_stall_w", ready0, 1'b0);
        check("t4_read_go", ready2, 1'b1);
        step();
        free_id = 16'h0020;
        @(negedge clk);
        check("t4_prerel", ready0, 1'b0);
        step();
        free_id = '0;
        @(negedge clk);
        check("t4_postrel", ready0, 1'b1);
        step();
        @(negedge clk);
        check("t4_id5_wb", wb_id, 8'd5);
        check("t4_id5_htu", htu_id, 8'd5);

        // Release and allocation of different bits in the same cycle
        step();
        push(0, 3'b001, 28'h0003000, 128'hA);
        push(0, 3'b001, 28'h0003001, 128'hB);
        free_id = 16'h0003;
        @(negedge clk);
        check("t5_empty", ready0, 1'b0);
        step();
        free_id = 16'h0400;
        @(negedge clk);
        check("t5_go", ready0, 1'b1);
        step();
        free_id = '0;
        @(negedge clk);
        check("t5_id0", wb_id, 8'd0);
        step();
        push(0, 3'b001, 28'h0003002, 128'hC);
        @(negedge clk);
        check("t5_id1", wb_id, 8'd1);
        step();
        @(negedge clk);
        check("t5_id10", wb_id, 8'd10);
        step();

        // Reset while a write with ID 3 sits in the slot
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 3'b001, 28'h0004000 + 28'(i), 128'h0);
        end
        for (int i = 0; i < 4; i++) step();
        htu_ready = 1'b0;
        @(negedge clk);
        check("t6_id3", htu_id, 8'd3);
        check("t6_held", htu_valid, 1'b1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        htu_ready = 1'b1;
        push(0, 3'b001, 28'h0005000, 128'h5);
        push(2, 3'b000, 28'h0005001, 128'h0);
        @(negedge clk);
        check("t6_htu_off", htu_valid, 1'b0);
        check("t6_wb_off", wb_valid, 1'b0);
        check("t6_rr0", ready0, 1'b1);
        step();
        @(negedge clk);
        check("t6_free_id0", htu_id, 8'd0);
        step();
        step();

`ifdef XBAR_ARB_FIXED_PRIO_EN
        // Fixed priority keeps ch0 ahead of ch2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, 3'b000, 28'h0006000 + 28'(i), 128'h0);
            push(2, 3'b000, 28'h0007000 + 28'(i), 128'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fp_ch0", ready0, 1'b1);
            check("fp_ch2", ready2, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) step();
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xbar_req_arb.md
Name: xbar_req_arb

Overview:
- Request-side arbiter/scheduler of the cross bar; shares the single HTU request port and the write-buffer request port among mcash channels 0-2.
- Round-robin arbitration into a one-entry issue slot.
- Allocates a write-buffer ID to every write from a free-ID pool and reclaims IDs on release pulses from the write buffer.

Parameters:
- WBUF_DEPTH, 16: number of write-buffer IDs managed, 2..256; IDs 0..WBUF_DEPTH-1.
- NUM_CH, 3: channel count; fixed at 3, present for documentation.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- chN_valid_i  in  1  channel N request valid (N=0,1,2).
- chN_ready_o  out  1  channel N request accepted this cycle.
- chN_op_i  in  3  op; [1:0] 00 read, 01 write, 10 flush, 11 reserved (issued as read); [2] ignored.
- chN_addr_i  in  28  line address [31:4].
- chN_data_i  in  128  write data.
- xbar_htu_valid_o  out  1  HTU request valid.
- xbar_htu_ready_i  in  1  HTU ready.
- xbar_htu_ch_id_o  out  2  source channel.
- xbar_htu_opcode_o  out  2  op[1:0]; 11 forced to 00.
- xbar_htu_addr_o  out  32  {addr[31:4],4'b0}.
- xbar_htu_set_o  out  3  addr[6:4].
- xbar_htu_wbuffer_id_o  out  8  allocated ID, zero-extended; 0 for non-writes.
- xbar_wbuf_req_valid_o  out  1  write-data push valid (writes only).
- xbar_wbuf_req_ready_i  in  1  write buffer ready.
- xbar_wbuf_req_ch_id_o  out  2  source channel.
- xbar_wbuf_req_data_o  out  128  write data.
- xbar_wbuf_req_wbuffer_id_o  out  8  same ID as HTU side.
- xbar_wbuf_rtn_free_id_i  in  WBUF_DEPTH  one-hot/multi-hot ID release pulses.

Behaviour:
- Slot state: htu_pend, wbuf_pend flags plus registered request fields. Slot is busy iff htu_pend|wbuf_pend.
- htu_valid_o = htu_pend. wbuf_req_valid_o = wbuf_pend. Each flag clears on its own handshake (valid&ready). The two sides complete independently, in any order or in the same cycle.
- Accept condition: slot free, or slot completing this cycle (every pending flag handshaking). This gives back-to-back throughput of 1 request/cycle.
- Eligibility:
  - chN is eligible if chN_valid_i and the op is not a write, or it is a write and at least one ID is free.
  - An ineligible write is skipped; other channels may be granted.
- Round-robin:
  - Search starts at rr_ptr and takes the first eligible channel, wrapping 2->0.
  - On a grant, rr_ptr <= granted+1 mod 3.
  - rr_ptr resets to 0.
- chN_ready_o is high only in the grant cycle for N. At most one ready per cycle. Sources hold valid/payload until ready.
- On grant: payload is registered; htu_pend<=1; wbuf_pend<=is_write.
- ID allocation:
  - free_map[WBUF_DEPTH] resets all-ones.
  - A write grant takes the lowest set bit and clears it.
  - Release: free_map |= free_id_i.
  - Allocation and release of different bits in the same cycle both take effect.
  - A release of an already-free bit has no effect.
  - Release and reallocation of the same bit in the same cycle are not possible: allocation sees pre-release free_map, so a released ID is allocatable next cycle.
- Pool empty: writes stall (ready low); reads and flushes proceed.
- Outputs with their slot flag low hold their last values. After reset all data fields are 0.
- Reset values: all valid/ready outputs 0; all fields 0; free_map all-ones; rr_ptr 0.
- Reset mid-transaction drops the slot contents. The ID bitmap is restored to all-free.

Optional Feature:
- XBAR_ARB_FIXED_PRIO_EN defined: fixed priority ch0>ch1>ch2 over eligible channels; rr_ptr not implemented.
- Undefined: round-robin as above.

Test Plan:
- Reset, then ch0 read addr 0x1234567 with htu_ready=1 -> next cycle htu_valid=1, addr=0x12345670, set=3'b111, ch_id=0, opcode=00; wbuf_req_valid stays 0.
- ch0/ch1/ch2 all valid reads, htu_ready=1 -> grants 0,1,2,0,1,2 one per cycle; ready_o one-hot each cycle.
- ch1 write, htu_ready=1, wbuf_ready=0 for 3 cycles -> HTU handshake in cycle 1; slot held; ch0 read not granted until wbuf handshakes; both sides show wbuffer_id=0.
- WBUF_DEPTH=16, 16 writes with no release -> IDs 0..15; 17th write stalls while ch2 read is granted. Pulse free_id=16'h0020 -> stalled write granted next cycle with ID 5.
- Assert rst_i=0 while htu_pend=1 with ID 3 allocated -> next cycle all valids 0, free_map=16'hFFFF, rr_ptr=0.
- With XBAR_ARB_FIXED_PRIO_EN, ch0 and ch2 continuously valid reads -> ch0 granted every cycle, ch2 never.
